// File: rtl/capture_pkg.sv
// Shared types and defaults for the capture engine: FSM state encoding,
// default address/data widths and the capture-length saturation helper.
package capture_pkg;

    localparam int unsigned CAP_AW = 11;
    localparam int unsigned CAP_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // A requested length of 0, or anything beyond the memory, means "fill it".
    function automatic int unsigned sat_len(input int unsigned len, input int unsigned depth);
        if (len == 0 || len > depth) return depth;
        return len;
    endfunction

endpackage

// File: rtl/capture_mem_writer.sv
// Stream-to-memory capture engine: writes accepted samples to consecutive addresses.
// Optional feature: define CAPTURE_TRIG_EN to make ARMED wait for trig.
module capture_mem_writer
    import capture_pkg::*;
#(
    parameter  int unsigned AW    = CAP_AW,
    parameter  int unsigned DW    = CAP_DW,
    localparam int unsigned DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          abort,
    input  logic          trig,
    input  logic [AW:0]   cap_len,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_count
);

    cap_state_t  state;
    logic [AW:0] len_q;

`ifndef CAPTURE_TRIG_EN
    logic unused_trig;
    assign unused_trig = trig;
`endif

    assign s_ready = (state == ST_CAPTURE) && !abort;
    assign busy    = (state == ST_ARMED) || (state == ST_CAPTURE);

    // wr_count doubles as the write pointer: length never exceeds DEPTH, so
    // its low AW bits are the next address for the whole capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            mem_we   <= 1'b0;
            mem_a    <= '0;
            mem_d    <= '0;
            done     <= 1'b0;
            wr_count <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            state    <= ST_ARMED;
                            wr_count <= '0;
                            len_q    <= (AW+1)'(sat_len(32'(cap_len), DEPTH));
                        end
                    end
                    ST_ARMED: begin
`ifdef CAPTURE_TRIG_EN
                        if (trig) state <= ST_CAPTURE;
`else
                        state <= ST_CAPTURE;
`endif
                    end
                    ST_CAPTURE: begin
                        if (s_valid) begin
                            mem_we   <= 1'b1;
                            mem_a    <= wr_count[AW-1:0];
                            mem_d    <= s_data;
                            wr_count <= wr_count + 1'b1;
                            if (wr_count + 1'b1 == len_q) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_mem_writer.sv
// Directed bench for capture_mem_writer with a behavioural sample RAM.
// Honours CAPTURE_TRIG_EN the same way as the design.
module capture_ram_model #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] spo
);
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) if (we) mem[a] <= d;
    assign spo = mem[ra];
endmodule

module tb_capture_mem_writer;
    import capture_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        trig = 1'b0;
    logic [11:0] cap_len = '0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready, mem_we, busy, done;
    logic [10:0] mem_a;
    logic [15:0] mem_d;
    logic [11:0] wr_count;
    logic [10:0] ra = '0;
    logic [15:0] spo;

    int n_tests = 0;
    int n_fail  = 0;
    logic acc;

    // Write monitor, cleared by mon_clr
    logic        mon_clr = 1'b0;
    int          nwrites = 0, ndone = 0, addr_err = 0, done_nowe = 0;
    logic [10:0] exp_a = '0;

    always #5 clk = ~clk;

    capture_mem_writer #(.AW(11), .DW(16)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
        .cap_len(cap_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .busy(busy), .done(done),
        .wr_count(wr_count)
    );

    capture_ram_model #(.AW(11), .DW(16)) ram (
        .clk(clk), .we(mem_we), .a(mem_a), .d(mem_d), .ra(ra), .spo(spo)
    );

    always @(posedge clk) begin
        if (mon_clr) begin
            nwrites <= 0; ndone <= 0; addr_err <= 0; done_nowe <= 0; exp_a <= '0;
        end else if (!rst) begin
            if (mem_we) begin
                if (mem_a !== exp_a) addr_err <= addr_err + 1;
                exp_a   <= exp_a + 11'd1;
                nwrites <= nwrites + 1;
            end
            if (done) begin
                ndone <= ndone + 1;
                if (!mem_we) done_nowe <= done_nowe + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the upstream source advances its data on every accept.
    task automatic step();
        #1;
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (acc) s_data = s_data + 16'd1;
    endtask

    task automatic start(input logic [11:0] len, input logic [15:0] base, input logic t);
        cap_len = len; s_data = base; trig = t; arm = 1'b1; mon_clr = 1'b1;
        step();
        arm = 1'b0; mon_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] vpat;
        int k;

        step(); step();
        chk("rst_state",  32'(dut.state), 32'(ST_IDLE));
        chk("rst_ready",  32'(s_ready), 0);
        chk("rst_we",     32'(mem_we), 0);
        chk("rst_a",      32'(mem_a), 0);
        chk("rst_d",      32'(mem_d), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_done",   32'(done), 0);
        chk("rst_count",  32'(wr_count), 0);
        rst = 1'b0;
        step();

        // Four samples, trigger a few cycles after arm
        s_valid = 1'b1;
        start(12'd4, 16'hA000, 1'b0);
        chk("t1_armed", 32'(dut.state), 32'(ST_ARMED));
        chk("t1_busy",  32'(busy), 1);
`ifdef CAPTURE_TRIG_EN
        step(); step(); step();
        chk("t1_wait_state", 32'(dut.state), 32'(ST_ARMED));
        chk("t1_wait_ready", 32'(s_ready), 0);
`endif
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("t1_capture", 32'(dut.state), 32'(ST_CAPTURE));
        chk("t1_ready",   32'(s_ready), 1);
        chk("t1_no_we",   32'(mem_we), 0);
        step();
        chk("t1_we0", 32'(mem_we), 1);
        chk("t1_a0",  32'(mem_a), 0);
        chk("t1_d0",  32'(mem_d), 32'h0000A000);
        chk("t1_done0", 32'(done), 0);
        step(); step(); step();
        chk("t1_we3",   32'(mem_we), 1);
        chk("t1_a3",    32'(mem_a), 3);
        chk("t1_d3",    32'(mem_d), 32'h0000A003);
        chk("t1_done",  32'(done), 1);
        chk("t1_state", 32'(dut.state), 32'(ST_DONE));
        chk("t1_count", 32'(wr_count), 4);
        chk("t1_busy_off", 32'(busy), 0);
        step();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_we_off", 32'(mem_we), 0);
        chk("t1_ready_off", 32'(s_ready), 0);
        chk("t1_nwrites", 32'(nwrites), 4);
        chk("t1_ndone", 32'(ndone), 1);
        chk("t1_addr", 32'(addr_err), 0);
        chk("t1_done_we", 32'(done_nowe), 0);
        ra = 11'd0; #1;
        chk("t1_ram0", 32'(spo), 32'h0000A000);
        ra = 11'd3; #1;
        chk("t1_ram3", 32'(spo), 32'h0000A003);

        // Full-depth capture via cap_len = 0
        start(12'd0, 16'h5000, 1'b1);
        for (int i = 0; i < 2300 && done !== 1'b1; i++) step();
        trig = 1'b0;
        chk("t2_done_seen", 32'(done), 1);
        chk("t2_count", 32'(wr_count), 2048);
        chk("t2_a_last", 32'(mem_a), 2047);
        chk("t2_d_last", 32'(mem_d), 32'h000057FF);
        step();
        chk("t2_nwrites", 32'(nwrites), 2048);
        chk("t2_ndone", 32'(ndone), 1);
        chk("t2_addr", 32'(addr_err), 0);
        ra = 11'd0; #1;
        chk("t2_ram0", 32'(spo), 32'h00005000);
        ra = 11'd1024; #1;
        chk("t2_ram1024", 32'(spo), 32'h00005400);
        ra = 11'd2047; #1;
        chk("t2_ram2047", 32'(spo), 32'h000057FF);

        // Gappy source, three samples
        s_valid = 1'b0;
        start(12'd3, 16'hC000, 1'b1);
        step();
        trig = 1'b0;
        chk("t3_capture", 32'(dut.state), 32'(ST_CAPTURE));
        vpat = 8'b0001_0101;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            s_valid = vpat[i];
            step();
            chk($sformatf("t3_we%0d", i), 32'(mem_we), 32'(vpat[i]));
            if (vpat[i]) begin
                chk($sformatf("t3_a%0d", k), 32'(mem_a), 32'(k));
                chk($sformatf("t3_d%0d", k), 32'(mem_d), 32'h0000C000 + 32'(k));
                k++;
            end
        end
        chk("t3_nwrites", 32'(nwrites), 3);
        chk("t3_ndone", 32'(ndone), 1);
        chk("t3_state", 32'(dut.state), 32'(ST_DONE));

        // Abort on the second accept
        s_valid = 1'b1;
        start(12'd8, 16'hD000, 1'b1);
        step();
        trig = 1'b0;
        chk("t4_ready", 32'(s_ready), 1);
        step();
        chk("t4_we0", 32'(mem_we), 1);
        chk("t4_a0",  32'(mem_a), 0);
        abort = 1'b1; #1;
        chk("t4_ready_abort", 32'(s_ready), 0);
        step();
        abort = 1'b0; #1;
        chk("t4_idle", 32'(dut.state), 32'(ST_IDLE));
        chk("t4_no_we", 32'(mem_we), 0);
        chk("t4_no_done", 32'(done), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_ready_idle", 32'(s_ready), 0);
        step();
        chk("t4_nwrites", 32'(nwrites), 1);
        chk("t4_ndone", 32'(ndone), 0);

        // Arm ignored mid-capture; arm+abort in DONE goes to IDLE
        start(12'd4, 16'hE000, 1'b1);
        step();
        trig = 1'b0;
        step();
        arm = 1'b1; cap_len = 12'd2;
        step();
        arm = 1'b0;
        chk("t5_still_cap", 32'(dut.state), 32'(ST_CAPTURE));
        chk("t5_count_kept", 32'(wr_count), 2);
        step(); step();
        chk("t5_done", 32'(done), 1);
        chk("t5_state", 32'(dut.state), 32'(ST_DONE));
        chk("t5_count", 32'(wr_count), 4);
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        chk("t5_idle", 32'(dut.state), 32'(ST_IDLE));
        chk("t5_count_after", 32'(wr_count), 4);
        step();
        chk("t5_nwrites", 32'(nwrites), 4);

        // Reset in the middle of a capture
        start(12'd8, 16'h1000, 1'b1);
        step();
        trig = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_state", 32'(dut.state), 32'(ST_IDLE));
        chk("t6_we",    32'(mem_we), 0);
        chk("t6_a",     32'(mem_a), 0);
        chk("t6_d",     32'(mem_d), 0);
        chk("t6_count", 32'(wr_count), 0);
        chk("t6_done",  32'(done), 0);
        chk("t6_ready", 32'(s_ready), 0);

        // Trigger held low
`ifdef CAPTURE_TRIG_EN
        start(12'd2, 16'hF000, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("t7_held", 32'(dut.state), 32'(ST_ARMED));
        chk("t7_nwrites", 32'(nwrites), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t7_idle", 32'(dut.state), 32'(ST_IDLE));
`else
        start(12'd2, 16'hF000, 1'b0);
        chk("t7_ready_armed", 32'(s_ready), 0);
        step();
        chk("t7_ready", 32'(s_ready), 1);
        step(); step();
        chk("t7_done", 32'(done), 1);
        chk("t7_d", 32'(mem_d), 32'h0000F001);
        step();
        chk("t7_nwrites", 32'(nwrites), 2);
`endif
        s_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_mem_writer.md
# capture_mem_writer

Stream-to-memory capture engine that fills a 2048x16 sample memory, one write per accepted sample. It is the write side of the sample memory that a free-running address counter reads back on `spo`: it supplies the `we`/`a`/`d` port of that memory's write port. It sits between an upstream valid/ready sample source and the memory, and reports completion to control logic through `busy`/`done`.

## Interface
Parameters:
- `AW`, 11: memory address width.
- `DW`, 16: sample width.
- `DEPTH`, 2**AW: memory depth. Derived; not overridden.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `arm` in 1: start a new capture. Sampled in IDLE and DONE only.
- `abort` in 1: cancel the capture. Returns to IDLE from any state.
- `trig` in 1: trigger. Level-sampled in ARMED.
- `cap_len` in AW+1: number of samples to capture. Latched on `arm`. 0 means DEPTH; values above DEPTH saturate to DEPTH.
- `s_valid` in 1: upstream sample valid.
- `s_data` in DW: upstream sample.
- `s_ready` out 1: sample accepted when `s_valid && s_ready`.
- `mem_we` out 1: memory write enable.
- `mem_a` out AW: write address.
- `mem_d` out DW: write data.
- `busy` out 1: high in ARMED or CAPTURE.
- `done` out 1: one-cycle pulse when the final sample is written.
- `wr_count` out AW+1: number of samples written in the current or last capture.

## Operation
- States:
  - IDLE (reset state).
  - ARMED.
  - CAPTURE.
  - DONE.
- Transitions:
  - IDLE or DONE, `arm` → ARMED. This clears `wr_count` and the write pointer and latches the length.
  - ARMED, `trig`=1 → CAPTURE.
  - CAPTURE, final sample accepted → DONE.
  - `abort` in any state → IDLE. Abort takes priority over `arm`, `trig` and an accepted sample; the sample is not written and no `done` pulse is produced.
  - `arm` is ignored in ARMED and CAPTURE.
- `s_ready` = (state==CAPTURE) && !`abort`. The source is backpressured in every other state, so no sample is lost between captures.
- Each accepted sample is written to address `ptr`, where `ptr` starts at 0 and increments by 1 per accept. `ptr` never wraps within a capture, because the length is at most DEPTH.
- `wr_count` increments on each registered write; its final value equals the latched length.
- The memory is write-only from this block. Read-back is the reader's concern; this block imposes no read ordering.

## Timing
- Reset values:
  - state = IDLE.
  - `s_ready`=0, `mem_we`=0, `mem_a`=0, `mem_d`=0.
  - `busy`=0, `done`=0, `wr_count`=0.
- Write latency is 1 cycle: a sample accepted at edge N appears as `mem_we`=1 with `mem_a`/`mem_d` during the cycle following edge N. `mem_we` is high for exactly one cycle per accepted sample.
- `done` is asserted in the same cycle as the `mem_we` of the final sample. The state reads DONE from that cycle on.
- Back-to-back accepts are allowed: full throughput of 1 sample/cycle.
- Trigger-to-ready latency is 1 cycle: `trig` sampled at edge N means `s_ready`=1 from edge N onward.
- Reset mid-capture: the next cycle is IDLE with all outputs at reset values. A pending write is dropped.
- `arm` and `abort` asserted in the same cycle from DONE → IDLE.

## Configuration
- `CAPTURE_TRIG_EN` defined: ARMED waits for `trig` as described above.
- Undefined: ARMED transitions to CAPTURE unconditionally on the next cycle and `trig` is ignored. The port remains present.

## Structure
- Shared package `capture_pkg` holds:
  - The state enum: IDLE/ARMED/CAPTURE/DONE.
  - The defaults for `AW` and `DW`.
  - The length-saturation function: 0 or >DEPTH → DEPTH.
- No sub-module. The block is a single FSM with a pointer/counter and a write register stage.
- The bench instantiates a behavioural 2048x16 RAM model, `capture_ram_model`, for checking.

## Test plan
- Reset, then `arm` with `cap_len`=4 and `trig` at cycle 5, with `s_valid` held high and data 0xA000..0xA003 → writes at `mem_a` 0..3 on consecutive cycles, one `done` pulse with the last write, `wr_count`=4, state DONE.
- `cap_len`=0, continuous valid → 2048 writes at addresses 0..2047, `wr_count`=2048, no address wrap, `done` asserted once.
- `s_valid` toggled every other cycle in CAPTURE with `cap_len`=3 → exactly 3 writes, each 1 cycle after its accept, no write for cycles where `s_valid`=0.
- `abort` asserted on the 2nd accept of a `cap_len`=8 capture → only 1 write, no `done`, IDLE next cycle, `s_ready`=0.
- `arm` pulsed during CAPTURE, then `arm` and `abort` asserted together in DONE → first arm ignored and `wr_count` is kept; state IDLE, `wr_count` unchanged.
- `CAPTURE_TRIG_EN` undefined, `arm` with `trig` held 0 → `s_ready`=1 two cycles after `arm` and the capture completes normally.
